// File: rtl/mesi_bcast_sched.sv
// mesi_bcast_sched
// Picks one main-bus command at a time from four CPU ports (round-robin) and
// runs the coherence-bus sequence for it:
//   plain WR/RD        -> main-bus ack pulse on the next cycle
//   WR_BROAD/RD_BROAD  -> snoop the three other caches, collect their acks,
//                         enable the requester, then the main-bus ack pulse.
// Ports:
//   clk, rst (asynchronous, active low)
//   mbus_cmd{3..0}_i / mbus_addr{3..0}_i : requests, held until mbus_ack pulses
//   cbus_ack{3..0}_i                    : coherence acknowledges
//   mbus_ack{3..0}_o                    : one-cycle completion pulse
//   cbus_addr_o                         : latched address of the current winner
//   cbus_cmd{3..0}_o                    : snoop / enable commands
//   sched_err_o                         : sticky timeout flag
// Optional feature: define MESI_SCHED_TIMEOUT_EN to bound the SNOOP/ENABLE
// waits by TIMEOUT_CYCLES; otherwise waits are unbounded and sched_err_o is 0.
module mesi_bcast_sched #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd3_i,
  input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd2_i,
  input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd1_i,
  input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd0_i,
  input  logic [ADDR_WIDTH-1:0]     mbus_addr3_i,
  input  logic [ADDR_WIDTH-1:0]     mbus_addr2_i,
  input  logic [ADDR_WIDTH-1:0]     mbus_addr1_i,
  input  logic [ADDR_WIDTH-1:0]     mbus_addr0_i,
  input  logic                      cbus_ack3_i,
  input  logic                      cbus_ack2_i,
  input  logic                      cbus_ack1_i,
  input  logic                      cbus_ack0_i,
  output logic                      mbus_ack3_o,
  output logic                      mbus_ack2_o,
  output logic                      mbus_ack1_o,
  output logic                      mbus_ack0_o,
  output logic [ADDR_WIDTH-1:0]     cbus_addr_o,
  output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd3_o,
  output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd2_o,
  output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd1_o,
  output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd0_o,
  output logic                      sched_err_o
);

  localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR       = MBUS_CMD_WIDTH'(1);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_RD       = MBUS_CMD_WIDTH'(2);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR_BROAD = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_RD_BROAD = MBUS_CMD_WIDTH'(4);

  localparam logic [CBUS_CMD_WIDTH-1:0] CB_NOP      = CBUS_CMD_WIDTH'(0);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_EN_RD    = CBUS_CMD_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SNOOP  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  logic [3:0][MBUS_CMD_WIDTH-1:0] mcmd_s;
  logic [3:0][ADDR_WIDTH-1:0]     maddr_s;
  logic [3:0]                     cack_s;
  logic [3:0]                     req_vld_s;
  logic [3:0]                     drive_s;
  logic [3:0]                     hit_s;
  logic                           grant_vld_s;
  logic [1:0]                     grant_idx_s;

  state_e                         state_q, state_d;
  logic [1:0]                     rr_q, rr_d;
  logic [1:0]                     win_q, win_d;
  logic                           rd_q, rd_d;
  logic [3:0]                     mask_q, mask_d;
  logic [3:0]                     mbus_ack_q, mbus_ack_d;
  logic [3:0][CBUS_CMD_WIDTH-1:0] cbus_cmd_q, cbus_cmd_d;
  logic [ADDR_WIDTH-1:0]          cbus_addr_q, cbus_addr_d;

`ifdef MESI_SCHED_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic             unused_cfg_s;
  assign unused_cfg_s = ^TIMEOUT_CYCLES;
`endif

  assign mcmd_s  = {mbus_cmd3_i, mbus_cmd2_i, mbus_cmd1_i, mbus_cmd0_i};
  assign maddr_s = {mbus_addr3_i, mbus_addr2_i, mbus_addr1_i, mbus_addr0_i};
  assign cack_s  = {cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i};

  // Per-port request decode and "currently driven" flags (acks count only there).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_vld_s[i] = (mcmd_s[i] >= MB_WR) && (mcmd_s[i] <= MB_RD_BROAD);
      drive_s[i]   = (cbus_cmd_q[i] != CB_NOP);
    end
    hit_s = cack_s & drive_s;
  end

  // Round-robin search from rr_q; scanning backwards lets the nearest port win.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req_vld_s[rr_q + 2'(k)]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = rr_q + 2'(k);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Next-state and next-output computation for the broadcast sequencer.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    win_d       = win_q;
    rd_d        = rd_q;
    mask_d      = mask_q;
    mbus_ack_d  = 4'b0000;
    cbus_cmd_d  = cbus_cmd_q;
    cbus_addr_d = cbus_addr_q;
`ifdef MESI_SCHED_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_vld_s) begin
          win_d       = grant_idx_s;
          rd_d        = (mcmd_s[grant_idx_s] == MB_RD) || (mcmd_s[grant_idx_s] == MB_RD_BROAD);
          cbus_addr_d = maddr_s[grant_idx_s];
          rr_d        = grant_idx_s + 2'd1;
          if (mcmd_s[grant_idx_s] >= MB_WR_BROAD) begin
            state_d = ST_SNOOP;
            // Winner never snoops itself, so its mask bit starts set.
            mask_d  = 4'b0001 << grant_idx_s;
            for (int i = 0; i < 4; i++) begin
              cbus_cmd_d[i] = (2'(i) == grant_idx_s) ? CB_NOP : (rd_d ? CB_RD_SNOOP : CB_WR_SNOOP);
            end
          end else begin
            state_d                  = ST_ACK;
            mbus_ack_d[grant_idx_s]  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SNOOP: begin
        mask_d = mask_q | hit_s;
        for (int i = 0; i < 4; i++) begin
          if (hit_s[i]) begin
            cbus_cmd_d[i] = CB_NOP;
          end else begin
            cbus_cmd_d[i] = cbus_cmd_q[i];
          end
        end
        if (mask_d == 4'b1111) begin
          state_d           = ST_ENABLE;
          cbus_cmd_d[win_q] = rd_q ? CB_EN_RD : CB_EN_WR;
        end else begin
          state_d = ST_SNOOP;
        end
      end
      ST_ENABLE: begin
        if (hit_s[win_q]) begin
          cbus_cmd_d[win_q] = CB_NOP;
          state_d           = ST_ACK;
          mbus_ack_d[win_q] = 1'b1;
        end else begin
          state_d = ST_ENABLE;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef MESI_SCHED_TIMEOUT_EN
    // Counter runs only while stuck in SNOOP/ENABLE; any progress or other state clears it.
    if (((state_q == ST_SNOOP) || (state_q == ST_ENABLE)) && (state_d == state_q)) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        cbus_cmd_d = {4{CB_NOP}};
        err_d      = 1'b1;
        state_d    = ST_IDLE;
        cnt_d      = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= 2'd0;
      win_q       <= 2'd0;
      rd_q        <= 1'b0;
      mask_q      <= 4'b0000;
      mbus_ack_q  <= 4'b0000;
      cbus_cmd_q  <= {4{CB_NOP}};
      cbus_addr_q <= {ADDR_WIDTH{1'b0}};
`ifdef MESI_SCHED_TIMEOUT_EN
      cnt_q       <= {CNT_W{1'b0}};
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      win_q       <= win_d;
      rd_q        <= rd_d;
      mask_q      <= mask_d;
      mbus_ack_q  <= mbus_ack_d;
      cbus_cmd_q  <= cbus_cmd_d;
      cbus_addr_q <= cbus_addr_d;
`ifdef MESI_SCHED_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mbus_ack3_o = mbus_ack_q[3];
  assign mbus_ack2_o = mbus_ack_q[2];
  assign mbus_ack1_o = mbus_ack_q[1];
  assign mbus_ack0_o = mbus_ack_q[0];
  assign cbus_addr_o = cbus_addr_q;
  assign cbus_cmd3_o = cbus_cmd_q[3];
  assign cbus_cmd2_o = cbus_cmd_q[2];
  assign cbus_cmd1_o = cbus_cmd_q[1];
  assign cbus_cmd0_o = cbus_cmd_q[0];
`ifdef MESI_SCHED_TIMEOUT_EN
  assign sched_err_o = err_q;
`else
  assign sched_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mesi_bcast_sched.sv
`timescale 1ns/1ps
module tb_mesi_bcast_sched;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    cmd_r  [4];
  logic [AW-1:0] addr_r [4];
  logic [3:0]    cack_r;

  wire           mack3, mack2, mack1, mack0;
  wire [AW-1:0]  cbus_addr;
  wire [2:0]     cc3, cc2, cc1, cc0;
  wire           err;
  wire [3:0]     dut_mack = {mack3, mack2, mack1, mack0};
  wire [11:0]    dut_cmds = {cc3, cc2, cc1, cc0};

  always #5 clk = ~clk;

  mesi_bcast_sched dut (
    .clk(clk), .rst(rst),
    .mbus_cmd3_i(cmd_r[3]), .mbus_cmd2_i(cmd_r[2]), .mbus_cmd1_i(cmd_r[1]), .mbus_cmd0_i(cmd_r[0]),
    .mbus_addr3_i(addr_r[3]), .mbus_addr2_i(addr_r[2]), .mbus_addr1_i(addr_r[1]), .mbus_addr0_i(addr_r[0]),
    .cbus_ack3_i(cack_r[3]), .cbus_ack2_i(cack_r[2]), .cbus_ack1_i(cack_r[1]), .cbus_ack0_i(cack_r[0]),
    .mbus_ack3_o(mack3), .mbus_ack2_o(mack2), .mbus_ack1_o(mack1), .mbus_ack0_o(mack0),
    .cbus_addr_o(cbus_addr),
    .cbus_cmd3_o(cc3), .cbus_cmd2_o(cc2), .cbus_cmd1_o(cc1), .cbus_cmd0_o(cc0),
    .sched_err_o(err)
  );

  // Transaction-level reference: who still owes a snoop ack, whether the
  // requester's enable is outstanding, and which port is due its ack pulse.
  int            m_rr, m_w, m_ack_port;
  logic [3:0]    m_pend;
  bit            m_en, m_rd;
  logic [AW-1:0] m_addr;
  int            m_grants[$];
  int            d_acks[$];
  int            d_ack_cyc[$];
  int            cyc;
  int            tests = 0;
  int            fails = 0;

  logic [11:0] t3_cmds [10] = '{12'h241, 12'h241, 12'h240, 12'h240, 12'h200,
                                12'h200, 12'h018, 12'h018, 12'h000, 12'h000};
  logic [3:0]  t3_mack [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
  logic [3:0]  t3_cack [10] = '{4'h2, 4'h1, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h2, 4'h0, 4'h0};
  int          t4_order [5] = '{0, 1, 2, 3, 0};

  function automatic bit is_req(logic [2:0] c);
    return (c >= 3'd1) && (c <= 3'd4);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_rr = 0; m_w = 0; m_ack_port = -1; m_pend = 4'h0; m_en = 1'b0; m_rd = 1'b0; m_addr = '0;
  endfunction

  // Advance the reference by one clock using the inputs currently applied.
  function automatic void model_update();
    int p;
    if (m_ack_port >= 0) begin
      m_ack_port = -1;
    end else if (m_pend != 4'h0) begin
      m_pend = m_pend & ~cack_r;
      if (m_pend == 4'h0) m_en = 1'b1;
    end else if (m_en) begin
      if (cack_r[m_w]) begin
        m_en = 1'b0;
        m_ack_port = m_w;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        p = (m_rr + k) % 4;
        if (is_req(cmd_r[p])) begin
          m_w = p;
          m_rd = (cmd_r[p] == 3'd2) || (cmd_r[p] == 3'd4);
          m_addr = addr_r[p];
          m_rr = (p + 1) % 4;
          m_grants.push_back(p);
          if (cmd_r[p] >= 3'd3) m_pend = 4'hF & ~(4'b0001 << p);
          else m_ack_port = p;
          break;
        end
      end
    end
  endfunction

  function automatic logic [3:0] exp_mack();
    if (m_ack_port >= 0) return 4'(1 << m_ack_port);
    return 4'h0;
  endfunction

  function automatic logic [11:0] exp_cmds();
    logic [11:0] r;
    r = 12'h000;
    for (int i = 0; i < 4; i++) begin
      if (m_pend[i]) r[3*i +: 3] = m_rd ? 3'd2 : 3'd1;
      else if (m_en && (i == m_w)) r[3*i +: 3] = m_rd ? 3'd4 : 3'd3;
    end
    return r;
  endfunction

  // One clock: reference update, then compare and requester reaction on the falling edge.
  task automatic step();
    model_update();
    @(negedge clk);
    cyc++;
    check("mbus_ack", dut_mack, exp_mack());
    check("cbus_cmd", dut_cmds, exp_cmds());
    check("cbus_addr", cbus_addr, m_addr);
    check("sched_err", err, 1'b0);
    for (int p = 0; p < 4; p++) begin
      if (dut_mack[p]) begin
        cmd_r[p] = 3'd0;
        d_acks.push_back(p);
        d_ack_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_mack", dut_mack, 4'h0);
    check("rst_cmd", dut_cmds, 12'h000);
    check("rst_addr", cbus_addr, 32'h0);
    check("rst_err", err, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    rst = 1'b0;
    cack_r = 4'h0;
    for (int p = 0; p < 4; p++) begin
      cmd_r[p] = 3'd0;
      addr_r[p] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    check("por_mack", dut_mack, 4'h0);
    check("por_cmd", dut_cmds, 12'h000);
    check("por_addr", cbus_addr, 32'h0);
    rst = 1'b1;

    // Idle: all NOP (acks on undriven ports must be ignored).
    for (int n = 0; n < 10; n++) begin
      cack_r = 4'($urandom_range(0, 15));
      step();
    end
    cack_r = 4'h0;
    check("idle_cmd", dut_cmds, 12'h000);
    check("idle_mack", dut_mack, 4'h0);

    // Plain RD on port 2; port 1 shows a 5-7 code that must not count as a request.
    cmd_r[2] = 3'd2; addr_r[2] = 32'h0000_1000; cmd_r[1] = 3'd6;
    step();
    check("t2_ack", dut_mack, 4'b0100);
    check("t2_addr", cbus_addr, 32'h0000_1000);
    check("t2_cmd", dut_cmds, 12'h000);
    cmd_r[1] = 3'd0;
    step();
    check("t2_single", dut_mack, 4'h0);
    check("t2_model_rr", m_rr, 3);
    cmd_r[0] = 3'd1; addr_r[0] = 32'h0000_00A0;
    cmd_r[3] = 3'd2; addr_r[3] = 32'h0000_00B0;
    step();
    check("t2_ptr3", dut_mack, 4'b1000);
    check("t2_addr3", cbus_addr, 32'h0000_00B0);
    step();
    check("t2_gap", dut_mack, 4'h0);
    step();
    check("t2_then0", dut_mack, 4'b0001);
    check("t2_addr0", cbus_addr, 32'h0000_00A0);
    step();

    // WR_BROAD from port 1 with staggered snoop acks.
    cmd_r[1] = 3'd3; addr_r[1] = 32'hDEAD_BEE0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("t3_cmd", dut_cmds, t3_cmds[c]);
      check("t3_ack", dut_mack, t3_mack[c]);
      check("t3_addr", cbus_addr, 32'hDEAD_BEE0);
      cack_r = t3_cack[c];
    end
    cack_r = 4'h0;

    // All four RD_BROAD from pointer 0, then 0 and 3 compete after wrap.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      cmd_r[p] = 3'd4;
      addr_r[p] = 32'h0000_0100 * p;
    end
    cack_r = 4'hF;
    d_acks.delete(); d_ack_cyc.delete(); m_grants.delete();
    for (int n = 0; n < 40 && d_acks.size() < 4; n++) step();
    cmd_r[0] = 3'd4; cmd_r[3] = 3'd4;
    for (int n = 0; n < 20 && d_acks.size() < 5; n++) step();
    check("t4_count", d_acks.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < d_acks.size()) check("t4_order", d_acks[i], t4_order[i]);
      if (i < m_grants.size()) check("t4_model_order", m_grants[i], t4_order[i]);
    end
    if (d_ack_cyc.size() >= 2) check("t4_latency", d_ack_cyc[1] - d_ack_cyc[0], 4);
    for (int n = 0; n < 20 && d_acks.size() < 6; n++) step();
    check("t4_port3_served", d_acks.size(), 6);
    for (int p = 0; p < 4; p++) cmd_r[p] = 3'd0;
    cack_r = 4'h0;
    step();

    // Reset in the middle of a snoop with two of three acks collected.
    do_reset();
    cmd_r[2] = 3'd4; addr_r[2] = 32'h55AA_0000;
    step();
    check("t5_snoop", dut_cmds, 12'h412);
    cack_r = 4'b0011;
    step();
    check("t5_partial", dut_cmds, 12'h400);
    cack_r = 4'h0;
    do_reset();
    step();
    check("t5_restart", dut_cmds, 12'h412);
    check("t5_addr", cbus_addr, 32'h55AA_0000);
    cack_r = 4'hF;
    d_acks.delete();
    for (int n = 0; n < 10 && d_acks.size() < 1; n++) step();
    check("t5_served", d_acks.size(), 1);
    if (d_acks.size() > 0) check("t5_port", d_acks[0], 2);

    // Randomised traffic against the reference.
    for (int p = 0; p < 4; p++) cmd_r[p] = 3'd0;
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 4; p++) begin
        if (!is_req(cmd_r[p]) && ($urandom_range(0, 3) == 0)) begin
          cmd_r[p] = 3'($urandom_range(0, 7));
          addr_r[p] = $urandom;
        end
        cack_r[p] = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 699) == 0) do_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mesi_bcast_sched.md
Name: mesi_bcast_sched

Overview:
- Arbitrates main-bus commands from four CPU ports and sequences the resulting coherence-bus broadcast.
- Snoops are sent to the non-requesting caches; once all have acknowledged, the requester receives an enable command and then a main-bus acknowledge.
- Sits between the mbus and cbus interface groups, in front of the shared memory/coherence path.
- Only one transaction is in flight at a time; selection is round-robin.

Parameters:
- ADDR_WIDTH, 32, address width of mbus/cbus addresses.
- MBUS_CMD_WIDTH, 3, mbus command width.
- CBUS_CMD_WIDTH, 3, cbus command width.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset (one clock domain; reset asserts asynchronously, deasserts synchronously to clk)
- mbus_cmd3_i..mbus_cmd0_i  in  3 each  main-bus commands
- mbus_addr3_i..mbus_addr0_i  in  ADDR_WIDTH each  main-bus addresses
- cbus_ack3_i..cbus_ack0_i  in  1 each  coherence-bus acknowledges
- mbus_ack3_o..mbus_ack0_o  out  1 each  main-bus acknowledges, single-cycle pulse
- cbus_addr_o  out  ADDR_WIDTH  coherence address, common to all ports
- cbus_cmd3_o..cbus_cmd0_o  out  3 each  coherence commands
- sched_err_o  out  1  sticky timeout error

Behaviour:
- Encodings:
  - mbus: NOP=0, WR=1, RD=2, WR_BROAD=3, RD_BROAD=4; values 5-7 are treated as NOP.
  - cbus: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4.
- Reset values: all mbus_ack_o=0, cbus_cmd_o=NOP, cbus_addr_o=0, sched_err_o=0, rr pointer=0, FSM=IDLE.
- Requester protocol: a CPU holds a non-NOP command stable until it sees its mbus_ack_o pulse.
- Arbitration (IDLE):
  - Search starts at the rr pointer, then pointer+1 … pointer+3 mod 4.
  - The first port with a valid command wins.
  - At grant, the scheduler latches the winner index, command and address into cbus_addr_o.
  - After grant, the pointer becomes winner+1 mod 4 (wraps 3→0).
- FSM states: IDLE, SNOOP, ENABLE, ACK.
  - IDLE→ACK: winner issued plain WR/RD. No cbus activity.
  - IDLE→SNOOP: winner issued WR_BROAD/RD_BROAD.
  - SNOOP:
    - Drive WR_SNOOP (or RD_SNOOP) on the three non-winner cbus_cmd_o; the winner's port stays NOP.
    - Keep a 4-bit ack mask, with the winner's bit preset to 1.
    - A cbus_ack_i sampled high sets its bit; that port's cmd returns to NOP the next cycle.
    - An ack on a port not currently being driven is ignored.
    - Mask=1111 → ENABLE.
  - ENABLE:
    - Drive EN_WR/EN_RD on the winner's port until its cbus_ack_i is sampled high.
    - Then the winner's cmd becomes NOP → ACK.
  - ACK: pulse mbus_ack_o[winner] for one cycle → IDLE.
- Latency:
  - Plain command: grant at cycle N, ack pulse at N+1.
  - Broadcast with same-cycle acks: snoop at N+1, enable at N+2, ack pulse at N+3.
- Re-arbitration: the earliest next grant is the cycle after the ack pulse. The just-served port has lowest priority.
- Simultaneous requests: resolved by rotation only.
- Requester command changes mid-transaction: ignored; latched values are used.
- Reset mid-operation: immediate return to reset values. Any partial ack mask is discarded.
- cbus_addr_o holds its last value while in IDLE.

Optional Feature:
- Macro: MESI_SCHED_TIMEOUT_EN.
- Enabled:
  - An 8+-bit counter clears on entry to SNOOP or ENABLE and increments each cycle spent waiting.
  - Reaching TIMEOUT_CYCLES forces all cbus_cmd_o to NOP, sets sched_err_o (sticky until reset) and goes to IDLE with no mbus_ack_o pulse.
  - The rr pointer has already advanced at grant.
- Disabled: no counter; sched_err_o is tied 0; waits are unbounded.

Test Plan:
- Reset then idle: all commands NOP for 10 cycles → every output stays at its reset value, FSM stays IDLE.
- Port 2 issues RD (addr 0x0000_1000) → mbus_ack2_o pulses exactly one cycle after grant; cbus_cmd all NOP; pointer becomes 3.
- Port 1 issues WR_BROAD at 0xDEAD_BEE0, acks 0/2/3 arriving on cycles 1/3/5 after snoop start:
  - cbus_cmd0/2/3_o = WR_SNOOP, each dropping to NOP after its ack; cbus_cmd1_o stays NOP.
  - After the last ack, cbus_cmd1_o = EN_WR until cbus_ack1_i; then mbus_ack1_o pulses.
  - cbus_addr_o = 0xDEAD_BEE0 throughout.
- All four ports request RD_BROAD with pointer=0 → grants in order 0,1,2,3. Then port 0 re-requesting while port 3 also requests → port 0 is granted (pointer wrapped).
- Reset asserted during SNOOP with 2 of 3 acks collected → outputs return to reset values asynchronously. After release, the same request restarts a full snoop to all three others.
- With MESI_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=8, port 0 RD_BROAD with port 3 never acking → abort after 8 waiting cycles: sched_err_o=1, no mbus_ack0_o, next request is still served.
